number_hit_detector: RTL and testbench
======================================

# number_hit_detector

Per-frame collision arbiter between the player sprite and the on-screen number objects. It watches the player drawing request and the per-number drawing requests pixel by pixel across a whole VGA frame. At the next frame boundary it issues at most one single-cycle hit pulse on the `singleHit` vector that drives the multiple-numbers display stage. It also keeps a saturating hit counter for the score logic and enforces a post-hit cooldown in frames.

## Interface
Parameters:
- NUMBERS, 3, number of number objects; width of the per-number vectors.
- COOLDOWN_FRAMES, 30, frames ignored after a hit; 0 disables cooldown.
- SCORE_W, 8, width of hitCount.
- IDX_W, $clog2(NUMBERS) with a minimum of 1, width of hitIndex.

Ports:
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- enable  in  1  game-running qualifier; when low, no overlaps are collected.
- clearScore  in  1  synchronous clear of hitCount.
- playerDR  in  1  player sprite drawing request for the current pixel.
- numbersDR  in  NUMBERS  per-number drawing requests for the current pixel.
- singleHit  out  NUMBERS  one-hot hit pulse, high for exactly one cycle.
- hitValid  out  1  high in the same cycle as singleHit.
- hitIndex  out  IDX_W  index of the last number hit; holds between hits.
- hitCount  out  SCORE_W  total hits, saturating.
- coolingDown  out  1  high while the FSM is in COOLDOWN.

## Operation
- The FSM has three states: COLLECT, REPORT and COOLDOWN. Reset state is COLLECT.
- pending[NUMBERS-1:0] is the internal overlap accumulator.
- **COLLECT:**
  - Each cycle with enable=1: pending |= numbersDR & {NUMBERS{playerDR}}.
  - On startOfFrame, the current cycle's overlap is OR'd in first and counts toward the ending frame.
  - If the resulting pending is nonzero: latch chosen = lowest set index, go to REPORT.
  - Otherwise clear pending and stay in COLLECT.
  - With enable=0: pending is held at 0 and startOfFrame produces no hit.
- **REPORT (one cycle):**
  - singleHit = one-hot(chosen), hitValid=1, hitIndex=chosen.
  - hitCount increments, saturating at 2^SCORE_W-1.
  - pending is cleared.
  - Next state: COLLECT if COOLDOWN_FRAMES==0; otherwise COOLDOWN with frameCnt=COOLDOWN_FRAMES.
  - Higher-index overlaps in the same frame are discarded, not deferred.
- **COOLDOWN:**
  - Overlaps are ignored and pending stays 0.
  - Each startOfFrame decrements frameCnt.
  - A startOfFrame with frameCnt==1 returns the FSM to COLLECT; the frame starting at that pulse is collected.
- **clearScore:** sets hitCount to 0 the next cycle. It takes priority over a simultaneous REPORT increment, so the count ends at 0. It has no effect on the FSM.
- **enable dropped mid-frame:** pending clears the next cycle. enable has no effect on REPORT or COOLDOWN progress.
- **startOfFrame in REPORT:** ignored. This cannot occur with real VGA timing.

## Timing
- All outputs are registered. Reset values: singleHit=0, hitValid=0, hitIndex=0, hitCount=0, coolingDown=0. Internal reset values: pending=0, frameCnt=0.
- Hit latency: startOfFrame in cycle T with pending≠0 gives singleHit/hitValid high in cycle T+1 only. hitCount and hitIndex are updated in T+2.
- coolingDown rises in T+2 and falls the cycle after the startOfFrame that ends the cooldown.
- reset asserted in any state, including REPORT: all of the above return to reset values the next cycle, with no pulse emitted.
- Throughput: at most one hit per frame, and at most one per COOLDOWN_FRAMES+1 frames when cooldown is enabled.

## Test plan
- **Single overlap:** reset, enable=1, playerDR=1 and numbersDR=3'b010 for 5 cycles, then startOfFrame. Expect singleHit=3'b010 for exactly 1 cycle; hitIndex=1 and hitCount=1 the cycle after.
- **Priority:** overlaps on numbers 2 and 0 in one frame, then startOfFrame. Expect singleHit=3'b001; number 2 produces no later pulse.
- **Cooldown with COOLDOWN_FRAMES=2:**
  - A hit, then continuous overlap on number 1 across the next 2 frames: no pulses, coolingDown=1.
  - The overlap continues in the third frame: hit on its closing startOfFrame.
- **Boundary overlap:** overlap present only in the same cycle as startOfFrame. Expect a pulse in the next cycle.
- **Saturation and clearing:**
  - SCORE_W=2 and 5 hits: hitCount reads 3.
  - clearScore coincident with a REPORT cycle: hitCount=0.
- **Reset and enable:**
  - reset asserted in the REPORT cycle: singleHit=0 that cycle, state COLLECT afterwards.
  - enable=0 during an overlapping frame: no pulse.

Source files
------------

// File: rtl/number_hit_detector_if.sv
// rtl/number_hit_detector_if.sv - drawing-request inputs and hit outputs of the number hit detector
interface number_hit_detector_if #(
    parameter int NUMBERS = 3,
    parameter int SCORE_W = 8,
    parameter int IDX_W   = (NUMBERS > 1) ? $clog2(NUMBERS) : 1
);
    logic               startOfFrame;
    logic               enable;
    logic               clearScore;
    logic               playerDR;
    logic [NUMBERS-1:0] numbersDR;
    logic [NUMBERS-1:0] singleHit;
    logic               hitValid;
    logic [IDX_W-1:0]   hitIndex;
    logic [SCORE_W-1:0] hitCount;
    logic               coolingDown;

    // Video/game side that feeds pixels and consumes hits.
    modport master (
        output startOfFrame, enable, clearScore, playerDR, numbersDR,
        input  singleHit, hitValid, hitIndex, hitCount, coolingDown
    );

    modport slave (
        input  startOfFrame, enable, clearScore, playerDR, numbersDR,
        output singleHit, hitValid, hitIndex, hitCount, coolingDown
    );
endinterface

// File: rtl/number_hit_detector.sv
// rtl/number_hit_detector.sv - per-frame player/number collision arbiter with score and cooldown
module number_hit_detector #(
    parameter int NUMBERS         = 3,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int SCORE_W         = 8,
    parameter int IDX_W           = (NUMBERS > 1) ? $clog2(NUMBERS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    number_hit_detector_if.slave  bus
);
    localparam int CNT_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        REPORT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t             state_q,       state_d;
    logic [NUMBERS-1:0] pending_q,     pending_d;
    logic [IDX_W-1:0]   chosen_q,      chosen_d;
    logic [CNT_W-1:0]   frame_cnt_q,   frame_cnt_d;
    logic [NUMBERS-1:0] single_hit_q,  single_hit_d;
    logic               hit_valid_q,   hit_valid_d;
    logic [IDX_W-1:0]   hit_index_q,   hit_index_d;
    logic [SCORE_W-1:0] hit_count_q,   hit_count_d;
    logic               cooling_q,     cooling_d;

    logic [NUMBERS-1:0] overlap;
    logic [NUMBERS-1:0] acc;
    logic [IDX_W-1:0]   lowest_idx;

    assign overlap = bus.numbersDR & {NUMBERS{bus.playerDR}};
    // The boundary pixel's overlap still belongs to the frame that is ending.
    assign acc     = pending_q | overlap;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUMBERS - 1; i >= 0; i--) begin
            if (acc[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        chosen_d     = chosen_q;
        frame_cnt_d  = frame_cnt_q;
        single_hit_d = '0;
        hit_valid_d  = 1'b0;
        hit_index_d  = hit_index_q;
        hit_count_d  = hit_count_q;
        cooling_d    = cooling_q;

        case (state_q)
            COLLECT: begin
                if (!bus.enable) begin
                    pending_d = '0;
                end else if (bus.startOfFrame) begin
                    pending_d = '0;
                    if (|acc) begin
                        chosen_d     = lowest_idx;
                        single_hit_d = NUMBERS'(1) << lowest_idx;
                        hit_valid_d  = 1'b1;
                        state_d      = REPORT;
                    end
                end else begin
                    pending_d = acc;
                end
            end

            REPORT: begin
                pending_d   = '0;
                hit_index_d = chosen_q;
                if (hit_count_q != {SCORE_W{1'b1}}) begin
                    hit_count_d = hit_count_q + 1'b1;
                end
                if (COOLDOWN_FRAMES == 0) begin
                    state_d = COLLECT;
                end else begin
                    state_d     = COOLDOWN;
                    frame_cnt_d = CNT_W'(COOLDOWN_FRAMES);
                    cooling_d   = 1'b1;
                end
            end

            COOLDOWN: begin
                pending_d = '0;
                if (bus.startOfFrame) begin
                    if (frame_cnt_q <= CNT_W'(1)) begin
                        state_d     = COLLECT;
                        frame_cnt_d = '0;
                        cooling_d   = 1'b0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d   = COLLECT;
                pending_d = '0;
                cooling_d = 1'b0;
            end
        endcase

        // A score clear wins over a same-cycle increment.
        if (bus.clearScore) begin
            hit_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= COLLECT;
            pending_q    <= '0;
            chosen_q     <= '0;
            frame_cnt_q  <= '0;
            single_hit_q <= '0;
            hit_valid_q  <= 1'b0;
            hit_index_q  <= '0;
            hit_count_q  <= '0;
            cooling_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            chosen_q     <= chosen_d;
            frame_cnt_q  <= frame_cnt_d;
            single_hit_q <= single_hit_d;
            hit_valid_q  <= hit_valid_d;
            hit_index_q  <= hit_index_d;
            hit_count_q  <= hit_count_d;
            cooling_q    <= cooling_d;
        end
    end

    assign bus.singleHit   = single_hit_q;
    assign bus.hitValid    = hit_valid_q;
    assign bus.hitIndex    = hit_index_q;
    assign bus.hitCount    = hit_count_q;
    assign bus.coolingDown = cooling_q;
endmodule

// File: tb/tb_number_hit_detector.sv
// tb/tb_number_hit_detector.sv - directed self-checking bench for number_hit_detector
module tb_number_hit_detector;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    number_hit_detector_if #(.NUMBERS(3), .SCORE_W(2), .IDX_W(2)) dut_if ();

    number_hit_detector #(
        .NUMBERS(3),
        .COOLDOWN_FRAMES(2),
        .SCORE_W(2),
        .IDX_W(2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_sof();
        dut_if.startOfFrame = 1'b1;
        tick();
        dut_if.startOfFrame = 1'b0;
    endtask

    task automatic set_dr(input logic p, input logic [2:0] n);
        dut_if.playerDR  = p;
        dut_if.numbersDR = n;
    endtask

    // Called in the cycle after REPORT; two frame boundaries end the cooldown.
    task automatic exit_cooldown(input string tag);
        set_dr(1'b0, 3'b000);
        for (int f = 0; f < 2; f++) begin
            check({tag, "_cd_on"}, dut_if.coolingDown, 1'b1);
            ticks(3);
            do_sof();
            check({tag, "_cd_nohit"}, dut_if.hitValid, 1'b0);
        end
        check({tag, "_cd_off"}, dut_if.coolingDown, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        dut_if.startOfFrame = 1'b0;
        dut_if.enable       = 1'b0;
        dut_if.clearScore   = 1'b0;
        set_dr(1'b0, 3'b000);
        @(negedge clk);
        ticks(2);
        reset = 1'b0;
        check("rst_singleHit", dut_if.singleHit, 3'b000);
        check("rst_hitValid",  dut_if.hitValid, 1'b0);
        check("rst_hitIndex",  dut_if.hitIndex, 2'd0);
        check("rst_hitCount",  dut_if.hitCount, 2'd0);
        check("rst_cooling",   dut_if.coolingDown, 1'b0);

        // Single overlap on number 1
        dut_if.enable = 1'b1;
        set_dr(1'b1, 3'b010);
        ticks(5);
        set_dr(1'b0, 3'b000);
        do_sof();
        check("single_pulse",  dut_if.singleHit, 3'b010);
        check("single_valid",  dut_if.hitValid, 1'b1);
        check("single_cnt_T1", dut_if.hitCount, 2'd0);
        tick();
        check("single_pulse_end", dut_if.singleHit, 3'b000);
        check("single_valid_end", dut_if.hitValid, 1'b0);
        check("single_index",  dut_if.hitIndex, 2'd1);
        check("single_count",  dut_if.hitCount, 2'd1);
        exit_cooldown("single");

        // Numbers 2 and 0 in one frame: 0 wins, 2 is dropped
        set_dr(1'b1, 3'b100);
        ticks(3);
        set_dr(1'b1, 3'b001);
        ticks(3);
        set_dr(1'b0, 3'b000);
        do_sof();
        check("prio_pulse", dut_if.singleHit, 3'b001);
        tick();
        check("prio_index", dut_if.hitIndex, 2'd0);
        check("prio_count", dut_if.hitCount, 2'd2);
        exit_cooldown("prio");
        ticks(3);
        do_sof();
        check("prio_no_deferred", dut_if.hitValid, 1'b0);

        // Continuous overlap through a two-frame cooldown
        set_dr(1'b1, 3'b010);
        ticks(4);
        do_sof();
        check("cd_first_hit", dut_if.singleHit, 3'b010);
        tick();
        check("cd_rise", dut_if.coolingDown, 1'b1);
        ticks(3);
        do_sof();
        check("cd_f1_nohit", dut_if.hitValid, 1'b0);
        check("cd_f1_cool",  dut_if.coolingDown, 1'b1);
        ticks(4);
        do_sof();
        check("cd_f2_nohit", dut_if.hitValid, 1'b0);
        check("cd_fall",     dut_if.coolingDown, 1'b0);
        ticks(4);
        do_sof();
        check("cd_third_hit", dut_if.singleHit, 3'b010);
        tick();
        check("cd_sat_count", dut_if.hitCount, 2'd3);
        exit_cooldown("cd");

        // Overlap only on the boundary pixel; fifth hit keeps the count saturated
        ticks(4);
        set_dr(1'b1, 3'b100);
        do_sof();
        set_dr(1'b0, 3'b000);
        check("edge_pulse", dut_if.singleHit, 3'b100);
        tick();
        check("edge_index", dut_if.hitIndex, 2'd2);
        check("edge_sat5",  dut_if.hitCount, 2'd3);
        exit_cooldown("edge");

        // clearScore in the REPORT cycle
        set_dr(1'b1, 3'b001);
        ticks(3);
        set_dr(1'b0, 3'b000);
        do_sof();
        check("clr_pulse", dut_if.singleHit, 3'b001);
        dut_if.clearScore = 1'b1;
        tick();
        dut_if.clearScore = 1'b0;
        check("clr_count", dut_if.hitCount, 2'd0);
        check("clr_cool",  dut_if.coolingDown, 1'b1);
        exit_cooldown("clr");
        set_dr(1'b1, 3'b010);
        ticks(2);
        set_dr(1'b0, 3'b000);
        do_sof();
        tick();
        check("clr_recount", dut_if.hitCount, 2'd1);
        exit_cooldown("clr2");

        // reset during REPORT
        set_dr(1'b1, 3'b010);
        ticks(3);
        set_dr(1'b0, 3'b000);
        do_sof();
        check("rstrep_pulse", dut_if.hitValid, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstrep_single", dut_if.singleHit, 3'b000);
        check("rstrep_valid",  dut_if.hitValid, 1'b0);
        check("rstrep_count",  dut_if.hitCount, 2'd0);
        check("rstrep_index",  dut_if.hitIndex, 2'd0);
        check("rstrep_cool",   dut_if.coolingDown, 1'b0);
        set_dr(1'b1, 3'b001);
        ticks(2);
        set_dr(1'b0, 3'b000);
        do_sof();
        check("rstrep_collect", dut_if.singleHit, 3'b001);
        tick();
        exit_cooldown("rstrep");

        // reset coincident with the frame boundary suppresses the pulse
        set_dr(1'b1, 3'b100);
        ticks(3);
        reset = 1'b1;
        do_sof();
        reset = 1'b0;
        set_dr(1'b0, 3'b000);
        check("rstsof_nopulse", dut_if.hitValid, 1'b0);

        // enable low for a whole overlapping frame
        dut_if.enable = 1'b0;
        set_dr(1'b1, 3'b111);
        ticks(4);
        do_sof();
        check("en_off_nopulse", dut_if.hitValid, 1'b0);

        // enable dropped for one cycle mid-frame discards earlier overlap
        dut_if.enable = 1'b1;
        set_dr(1'b1, 3'b010);
        ticks(3);
        set_dr(1'b0, 3'b000);
        dut_if.enable = 1'b0;
        tick();
        dut_if.enable = 1'b1;
        ticks(3);
        do_sof();
        check("en_drop_nopulse", dut_if.hitValid, 1'b0);
        check("en_drop_cool",    dut_if.coolingDown, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
